// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - inst/data arbiter onto one SRAM-like port with grant lock and response tag FIFO
// Optional round-robin tie-break on simultaneous requests: MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inst_req,
    input  logic                         inst_wr,
    input  logic [1:0]                   inst_size,
    input  logic [3:0]                   inst_wstrb,
    input  logic [ADDR_W-1:0]            inst_addr,
    input  logic [DATA_W-1:0]            inst_wdata,
    output logic                         inst_addr_ok,
    output logic                         inst_data_ok,
    output logic [DATA_W-1:0]            inst_rdata,
    input  logic                         data_req,
    input  logic                         data_wr,
    input  logic [1:0]                   data_size,
    input  logic [3:0]                   data_wstrb,
    input  logic [ADDR_W-1:0]            data_addr,
    input  logic [DATA_W-1:0]            data_wdata,
    output logic                         data_addr_ok,
    output logic                         data_data_ok,
    output logic [DATA_W-1:0]            data_rdata,
    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [3:0]                   mem_wstrb,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic                         resp_err
);

    localparam int CW = $clog2(MAX_OUTST) + 1;
    localparam int PW = $clog2(MAX_OUTST);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTST);

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [MAX_OUTST-1:0] tag_q, tag_d;
    logic                resp_err_q, resp_err_d;
    logic                gnt_vld, gnt_data;
    logic                full, empty, push, pop, head;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                last_q, last_d;
`endif

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        gnt_vld  = 1'b0;
        gnt_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (!full) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    gnt_data = (data_req && inst_req) ? ~last_q : data_req;
`else
                    gnt_data = data_req;
`endif
                    gnt_vld = data_req | inst_req;
                    if (gnt_vld && !mem_addr_ok)
                        state_d = gnt_data ? LOCK_D : LOCK_I;
                end
            end
            LOCK_I: begin
                gnt_vld = inst_req;
                if (mem_addr_ok)
                    state_d = IDLE;
            end
            LOCK_D: begin
                gnt_data = 1'b1;
                gnt_vld  = data_req;
                if (mem_addr_ok)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = gnt_vld;
    assign mem_wr    = gnt_data ? data_wr    : inst_wr;
    assign mem_size  = gnt_data ? data_size  : inst_size;
    assign mem_wstrb = gnt_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = gnt_data ? data_addr  : inst_addr;
    assign mem_wdata = gnt_data ? data_wdata : inst_wdata;

    assign inst_addr_ok = mem_addr_ok & mem_req & ~gnt_data;
    assign data_addr_ok = mem_addr_ok & mem_req &  gnt_data;

    // Tag bit per outstanding transaction: 1 = data side, 0 = inst side.
    assign push = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & ~empty;
    assign head = tag_q[rptr_q];

    always_comb begin
        tag_d      = tag_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        resp_err_d = resp_err_q | (mem_data_ok & empty);
        if (push) begin
            tag_d[wptr_q] = gnt_data;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop)
            rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign last_d = push ? gnt_data : last_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            tag_q      <= '0;
            resp_err_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            tag_q      <= tag_d;
            resp_err_q <= resp_err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop &  head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign outst_cnt    = cnt_q;
    assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  outst_cnt;
    logic        resp_err;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arbiter #(.MAX_OUTST(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outst_cnt(outst_cnt), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    // Call after inputs settle: checks which side is accepted and queues its response.
    task automatic expect_accept(input logic is_data, input logic [31:0] rd);
        chk("data_addr_ok", data_addr_ok, is_data);
        chk("inst_addr_ok", inst_addr_ok, !is_data);
        exp_q.push_back('{is_data: is_data, rdata: rd});
    endtask

    task automatic do_resp();
        exp_t e;
        next_cycle();
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            mem_data_ok = 1'b1;
            mem_rdata   = e.rdata;
            #1;
            chk("inst_data_ok", inst_data_ok, !e.is_data);
            chk("data_data_ok", data_data_ok, e.is_data);
            chk("rdata", e.is_data ? data_rdata : inst_rdata, e.rdata);
        end
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("rst_cnt", outst_cnt, 0);
        chk("rst_resp_err", resp_err, 0);

        // Single inst read, response two cycles after accept
        next_cycle();
        inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1; #1;
        chk("t1_mem_addr", mem_addr, 32'h1c00_0000);
        expect_accept(0, 32'h0280_0000);
        next_cycle();
        inst_req = 0; mem_addr_ok = 0; #1;
        chk("t1_cnt1", outst_cnt, 1);
        do_resp();
        next_cycle(); #1;
        chk("t1_cnt0", outst_cnt, 0);

        // Simultaneous requests: data first, then inst
        next_cycle();
        inst_req = 1; inst_addr = 32'h40; data_req = 1; data_addr = 32'h80; mem_addr_ok = 1; #1;
        expect_accept(1, 32'hd0d0_0001);
        next_cycle();
        data_req = 0; #1;
        expect_accept(0, 32'h1111_0002);
        next_cycle();
        inst_req = 0; mem_addr_ok = 0;
        do_resp();
        do_resp();

        // Data write stalled three cycles; inst must wait behind the lock
        next_cycle();
        data_req = 1; data_wr = 1; data_addr = 32'h100; data_wdata = 32'hcafe; mem_addr_ok = 0; #1;
        chk("t3_mem_req", mem_req, 1);
        chk("t3_mem_wr", mem_wr, 1);
        for (int c = 1; c < 3; c++) begin
            next_cycle();
            inst_req = 1; inst_addr = 32'h200; #1;
            chk("t3_mem_addr_hold", mem_addr, 32'h100);
            chk("t3_inst_addr_ok", inst_addr_ok, 0);
            chk("t3_data_addr_ok", data_addr_ok, 0);
        end
        next_cycle();
        mem_addr_ok = 1; #1;
        chk("t3_mem_addr_acc", mem_addr, 32'h100);
        expect_accept(1, 32'h0);
        next_cycle();
        data_req = 0; data_wr = 0; #1;
        chk("t3_mem_addr_inst", mem_addr, 32'h200);
        expect_accept(0, 32'h2222_0003);
        next_cycle();
        inst_req = 0; mem_addr_ok = 0;
        do_resp();
        do_resp();

        // Fill to MAX_OUTST; pop does not unblock issue in the same cycle
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            inst_req = 1; inst_addr = 32'h1000 + 4 * k; mem_addr_ok = 1; #1;
            expect_accept(0, 32'h3000_0000 + k);
        end
        next_cycle(); #1;
        chk("t4_cnt_full", outst_cnt, 4);
        chk("t4_mem_req_full", mem_req, 0);
        chk("t4_inst_addr_ok_full", inst_addr_ok, 0);
        do_resp();
        chk("t4_mem_req_pop", mem_req, 0);
        next_cycle(); #1;
        chk("t4_cnt3", outst_cnt, 3);
        chk("t4_mem_req_resume", mem_req, 1);
        expect_accept(0, 32'h3000_0004);
        next_cycle();
        inst_req = 0; mem_addr_ok = 0; #1;
        chk("t4_cnt_refull", outst_cnt, 4);
        repeat (4) do_resp();
        next_cycle(); #1;
        chk("t4_cnt_drain", outst_cnt, 0);

        // Stray response with nothing outstanding
        next_cycle();
        mem_data_ok = 1; mem_rdata = 32'hdead_beef; #1;
        chk("t5_inst_data_ok", inst_data_ok, 0);
        chk("t5_data_data_ok", data_data_ok, 0);
        next_cycle(); #1;
        chk("t5_resp_err", resp_err, 1);
        chk("t5_cnt", outst_cnt, 0);
        next_cycle();
        inst_req = 1; inst_addr = 32'h44; mem_addr_ok = 1; #1;
        expect_accept(0, 32'h0);
        next_cycle();
        inst_req = 0; mem_addr_ok = 0; #1;
        chk("t5_resp_err_held", resp_err, 1);
        chk("t5_cnt_inflight", outst_cnt, 1);
        reset = 1; #1;
        chk("t5_rst_resp_err", resp_err, 0);
        chk("t5_rst_cnt", outst_cnt, 0);
        exp_q.delete();
        next_cycle();
        reset = 0;

        // Continuous contention
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            inst_req = 1; data_req = 1; mem_addr_ok = 1; #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            expect_accept((k % 2) == 0, 32'h5000_0000 + k);
`else
            expect_accept(1, 32'h5000_0000 + k);
`endif
        end
        next_cycle();
        inst_req = 0; data_req = 0; mem_addr_ok = 0;
        repeat (4) do_resp();
        next_cycle(); #1;
        chk("t6_cnt_drain", outst_cnt, 0);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester of the pipelined CPU core.
- The address phase is arbitrated with a grant lock, so a request held by the memory side is never retracted.
- In-order read/write responses are routed back to the originating requester through a tag FIFO of outstanding transactions.
- Sits between the core's inst/data SRAM-like interfaces and the downstream AXI bridge.

Parameters:
- MAX_OUTST, 4, maximum outstanding transactions (tag FIFO depth); power of 2, ≥2
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  instruction-side request
- inst_wr  in  1  1 = write
- inst_size  in  2  0/1/2 = byte/half/word
- inst_wstrb  in  4  byte strobes
- inst_addr  in  ADDR_W  address
- inst_wdata  in  DATA_W  write data
- inst_addr_ok  out  1  address phase accepted
- inst_data_ok  out  1  response valid
- inst_rdata  out  DATA_W  read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  same widths as inst_*  data-side request
- data_addr_ok, data_data_ok  out  1  data-side handshakes
- data_rdata  out  DATA_W  data-side read data
- mem_req  out  1  downstream request
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  muxed request fields
- mem_addr_ok  in  1  downstream address accept
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  DATA_W  downstream read data
- outst_cnt  out  $clog2(MAX_OUTST)+1  outstanding transaction count
- resp_err  out  1  sticky flag: response arrived with no outstanding transaction

Behaviour:
- Reset values: lock state IDLE, tag FIFO empty, outst_cnt 0, resp_err 0. This gives mem_req 0, both *_addr_ok 0 and both *_data_ok 0.
- Address path is combinational (zero added latency):
  - mem_* fields = granted requester's fields.
  - Granted requester's addr_ok = mem_addr_ok & mem_req.
  - Non-granted requester's addr_ok = 0.
- Lock FSM, states IDLE, LOCK_I, LOCK_D:
  - IDLE: if outst_cnt == MAX_OUTST, no grant and mem_req 0. Otherwise grant data if data_req, else inst if inst_req (fixed data priority); mem_req = grant valid.
  - IDLE exit: if a grant is made and mem_addr_ok = 0, go to LOCK_D or LOCK_I.
  - LOCK_x: only requester x is forwarded; mem_req = x_req, fields held from x. On mem_addr_ok, return to IDLE. The other requester waits.
  - Requesters are required to hold req and fields stable until addr_ok. A requester dropping req in LOCK_x drops mem_req; the FSM stays in LOCK_x.
- Tag FIFO:
  - On each address handshake (mem_req & mem_addr_ok), push 1 bit: 0 = inst, 1 = data.
  - On mem_data_ok with FIFO non-empty, pop the head and assert the head requester's data_ok in the same cycle, with rdata = mem_rdata. The other requester's data_ok = 0.
  - Both rdata outputs are driven with mem_rdata unconditionally; only data_ok is steered.
- Counter arithmetic:
  - Push only: outst_cnt +1. Pop only: outst_cnt −1. Simultaneous push and pop: unchanged.
  - Full is evaluated on the registered count, so a pop in the same cycle does not unblock issue that cycle.
  - FIFO pointers wrap modulo MAX_OUTST.
- mem_data_ok while the FIFO is empty: no data_ok is asserted, no pointer moves, resp_err sets and stays set until reset.
- Write responses occupy FIFO entries like reads; responses are assumed to arrive in issue order.
- Reset asserted mid-operation: FIFO, counter and lock clear immediately (asynchronously); in-flight responses are lost.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: in IDLE with both requests asserted, the requester not granted most recently wins. A 1-bit last-grant register resets to inst, so data wins the first tie, and updates on every address handshake.
- Undefined: fixed data-over-inst priority; the last-grant register is absent.

Test Plan:
- Single inst read at addr 0x1c000000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with rdata 0x02800000 -> inst_addr_ok 1 in cycle 0; inst_data_ok 1 with inst_rdata 0x02800000 in cycle 2; outst_cnt 1 then 0.
- inst_req and data_req both high, mem_addr_ok = 1 -> data granted first, inst next cycle; FIFO order D,I; two mem_data_ok pulses -> data_data_ok then inst_data_ok.
- Data write to 0x100 with mem_addr_ok low for 3 cycles, inst_req raised in cycle 1 -> mem_addr stays 0x100 and inst_addr_ok stays 0 until cycle 3 accept; inst issued in cycle 4.
- MAX_OUTST = 4, four accepted reads with no responses -> outst_cnt 4, mem_req 0 despite inst_req; one mem_data_ok -> cnt 3, issue resumes the following cycle.
- mem_data_ok pulse with cnt 0 -> no data_ok on either side, resp_err 1 and held; reset pulse -> resp_err 0.
- With MEM_ARB_ROUND_ROBIN_EN and both requesting continuously, mem_addr_ok = 1 -> grants alternate D,I,D,I; without the macro -> D every cycle.
